// File: rtl/multiplier_1.sv
// Streaming COO sparse matrix-vector multiply accumulator.
// A four-stage pipeline (input, vector lookup, product, accumulate) runs alongside a drain FSM that pulses done.
module multiplier_1 #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned NUM_ROWS  = 8,
    parameter int unsigned VEC_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic [NUM_LANES-1:0][31:0] values,
    input  logic [NUM_LANES-1:0][31:0] col_id,
    input  logic [NUM_LANES-1:0][31:0] row_id,
    input  logic                       rdy,
    output logic [NUM_ROWS-1:0][31:0]  accum,
    output logic                       done
);

    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic                       s0_vld_q, s0_vld_d;
    logic [NUM_LANES-1:0][31:0] s0_val_q, s0_val_d;
    logic [NUM_LANES-1:0][31:0] s0_col_q, s0_col_d;
    logic [NUM_LANES-1:0][31:0] s0_row_q, s0_row_d;

    logic                       s1_vld_q, s1_vld_d;
    logic [NUM_LANES-1:0][31:0] s1_val_q, s1_val_d;
    logic [NUM_LANES-1:0][31:0] s1_x_q, s1_x_d;
    logic [NUM_LANES-1:0][31:0] s1_row_q, s1_row_d;

    logic [NUM_LANES-1:0]            s2_en_q, s2_en_d;
    logic [NUM_LANES-1:0][31:0]      s2_prod_q, s2_prod_d;
    logic [NUM_LANES-1:0][ROW_W-1:0] s2_row_q, s2_row_d;

    logic [NUM_ROWS-1:0][31:0] accum_q, accum_d;

    always_comb begin
        s0_vld_d = rdy;
        s0_val_d = values;
        s0_col_d = col_id;
        s0_row_d = row_id;

        s1_vld_d = s0_vld_q;
        s1_val_d = s0_val_q;
        s1_row_d = s0_row_q;
        s1_x_d   = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            s1_x_d[l] = (s0_col_q[l] < VEC_DEPTH) ? s0_col_q[l] + 32'd1 : '0;
        end

        s2_en_d   = '0;
        s2_prod_d = '0;
        s2_row_d  = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            // Invalid beats and padding rows are folded into one per-lane enable here.
            s2_en_d[l]   = s1_vld_q && (s1_row_q[l] < NUM_ROWS);
            s2_prod_d[l] = s1_val_q[l] * s1_x_q[l];
            s2_row_d[l]  = s1_row_q[l][ROW_W-1:0];
        end

        accum_d = accum_q;
        for (int unsigned r = 0; r < NUM_ROWS; r++) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                if (s2_en_q[l] && (s2_row_q[l] == ROW_W'(r))) begin
                    accum_d[r] = accum_d[r] + s2_prod_q[l];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rdy) state_d = S_RUN;
            end
            S_RUN: begin
                if (!rdy) begin
                    state_d = S_DRAIN;
                    cnt_d   = 2'd3;
                end
            end
            S_DRAIN: begin
                if (rdy) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = rdy ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_l) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            s0_vld_q  <= 1'b0;
            s0_val_q  <= '0;
            s0_col_q  <= '0;
            s0_row_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_val_q  <= '0;
            s1_x_q    <= '0;
            s1_row_q  <= '0;
            s2_en_q   <= '0;
            s2_prod_q <= '0;
            s2_row_q  <= '0;
            accum_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s0_vld_q  <= s0_vld_d;
            s0_val_q  <= s0_val_d;
            s0_col_q  <= s0_col_d;
            s0_row_q  <= s0_row_d;
            s1_vld_q  <= s1_vld_d;
            s1_val_q  <= s1_val_d;
            s1_x_q    <= s1_x_d;
            s1_row_q  <= s1_row_d;
            s2_en_q   <= s2_en_d;
            s2_prod_q <= s2_prod_d;
            s2_row_q  <= s2_row_d;
            accum_q   <= accum_d;
        end
    end

    assign accum = accum_q;

endmodule

// File: tb/tb_multiplier_1.sv
// Scoreboard bench for multiplier_1: a reference model pushes expected accum snapshots per beat.
// A monitor compares each snapshot three cycles after the beat is sampled and records done pulses.
module tb_multiplier_1;

    localparam int unsigned NL = 4;
    localparam int unsigned NR = 8;
    localparam int unsigned VD = 16;

    logic                clk = 1'b0;
    logic                rst_l = 1'b1;
    logic                rdy = 1'b0;
    logic [NL-1:0][31:0] values = '0;
    logic [NL-1:0][31:0] col_id = '0;
    logic [NL-1:0][31:0] row_id = '0;
    logic [NR-1:0][31:0] accum;
    logic                done;

    multiplier_1 #(.NUM_LANES(NL), .NUM_ROWS(NR), .VEC_DEPTH(VD)) dut (
        .clk    (clk),
        .rst_l  (rst_l),
        .values (values),
        .col_id (col_id),
        .row_id (row_id),
        .rdy    (rdy),
        .accum  (accum),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned         due;
        logic [NR-1:0][31:0] acc;
    } exp_t;

    exp_t                sb_q[$];
    exp_t                sb_e;
    logic [NR-1:0][31:0] model_acc = '0;
    logic [NR-1:0][31:0] acc_at_done = '0;
    int unsigned         cyc = 0;
    int unsigned         n_tests = 0;
    int unsigned         n_fail = 0;
    int unsigned         done_cnt = 0;
    int unsigned         done_cyc = 0;
    int unsigned         last_beat = 0;
    int unsigned         d0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] xval(input logic [31:0] c);
        return (c < VD) ? c + 32'd1 : 32'd0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            acc_at_done = accum;
        end
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            sb_e = sb_q.pop_front();
            for (int r = 0; r < NR; r++)
                check($sformatf("sb_c%0d_row%0d", cyc, r), accum[r], sb_e.acc[r]);
        end
    end

    task automatic beat(input logic [NL-1:0][31:0] v, input logic [NL-1:0][31:0] c,
                        input logic [NL-1:0][31:0] rw);
        exp_t e;
        values = v;
        col_id = c;
        row_id = rw;
        rdy    = 1'b1;
        for (int l = 0; l < NL; l++)
            if (rw[l] < NR) model_acc[rw[l][2:0]] = model_acc[rw[l][2:0]] + v[l] * xval(c[l]);
        e.due = cyc + 4;
        e.acc = model_acc;
        sb_q.push_back(e);
        last_beat = cyc + 1;
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            rdy = 1'b0;
            for (int l = 0; l < NL; l++) begin
                values[l] = $urandom | 32'd1;
                col_id[l] = $urandom_range(0, 19);
                row_id[l] = $urandom_range(0, 9);
            end
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_l = 1'b1;
        rdy   = 1'b0;
        sb_q.delete();
        model_acc = '0;
        @(negedge clk);
    endtask

    task automatic check_drain(input string tag);
        check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
        check({tag, "_done_delay"}, done_cyc - last_beat, 32'd4);
        for (int r = 0; r < NR; r++)
            check($sformatf("%s_acc_at_done_row%0d", tag, r), acc_at_done[r], model_acc[r]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        for (int r = 0; r < NR; r++) check($sformatf("rst_row%0d", r), accum[r], 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_l = 1'b0;

        // rdy=0 with nonzero data must be ignored
        for (int i = 0; i < 6; i++) begin
            idle(1);
            for (int r = 0; r < NR; r++) check($sformatf("norl_row%0d", r), accum[r], 32'd0);
            check("norl_done", {31'd0, done}, 32'd0);
        end

        d0 = done_cnt;
        beat({32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4});
        beat({32'd5, 32'd6, 32'd7, 32'd8}, {32'd5, 32'd6, 32'd7, 32'd8}, {32'd5, 32'd6, 32'd7, 32'd8});
        idle(8);
        check_drain("s1");
        check("s1_row0", accum[0], 32'd0);
        check("s1_row1", accum[1], 32'd2);
        check("s1_row2", accum[2], 32'd6);
        check("s1_row3", accum[3], 32'd12);
        check("s1_row4", accum[4], 32'd20);
        check("s1_row5", accum[5], 32'd30);
        check("s1_row6", accum[6], 32'd42);
        check("s1_row7", accum[7], 32'd56);

        // shared row in one beat, then an out-of-range column with padding lanes
        d0 = done_cnt;
        beat({4{32'd1}}, {4{32'd2}}, {4{32'd3}});
        beat({32'd7, 32'd8, 32'd9, 32'd99}, {32'd1, 32'd1, 32'd1, 32'd20}, {32'd9, 32'd8, 32'd12, 32'd0});
        idle(8);
        check_drain("s2");
        check("s2_row3", accum[3], 32'd24);
        check("s2_row0_col20", accum[0], 32'd0);

        // random stream with short gaps that must not end the stream
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            logic [NL-1:0][31:0] v, c, rw;
            for (int l = 0; l < NL; l++) begin
                v[l]  = $urandom;
                c[l]  = $urandom_range(0, 19);
                rw[l] = $urandom_range(0, 9);
            end
            beat(v, c, rw);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(8);
        check_drain("rnd");

        // reset while draining discards the in-flight beat
        beat({32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd2, 32'd3, 32'd4});
        idle(1);
        d0 = done_cnt;
        do_reset();
        for (int r = 0; r < NR; r++) check($sformatf("drst_row%0d", r), accum[r], 32'd0);
        check("drst_done", {31'd0, done}, 32'd0);
        rst_l = 1'b0;
        idle(8);
        check("drst_no_done", done_cnt - d0, 32'd0);
        for (int r = 0; r < NR; r++) check($sformatf("drst_after_row%0d", r), accum[r], 32'd0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
